// File: rtl/regfile_sequencer.sv
// regfile_sequencer: turns one-word commands (LDI/MOV/SWAP/CLR) into
// multi-cycle read/write sequences on a 6-entry, 8-bit register file.
module regfile_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_src,
    input  logic [2:0] cmd_dst,
    input  logic [7:0] cmd_imm,
    output logic       rf_save,
    output logic [2:0] rf_saveselector,
    output logic [7:0] rf_savebus,
    output logic [2:0] rf_loadselector,
    input  logic [7:0] rf_loadbus,
    output logic       done,
    output logic       error
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned OP_W   = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);
    localparam logic [OP_W-1:0]  OP_LDI   = OP_W'(0);
    localparam logic [OP_W-1:0]  OP_MOV   = OP_W'(1);
    localparam logic [OP_W-1:0]  OP_SWAP  = OP_W'(2);
    localparam logic [OP_W-1:0]  OP_CLR   = OP_W'(3);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ_A  = 3'd1,
        S_READ_B  = 3'd2,
        S_WRITE_A = 3'd3,
        S_WRITE_B = 3'd4,
        S_CLEAR   = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [OP_W-1:0]   r_op;
    logic [IDX_W-1:0]  r_src;
    logic [IDX_W-1:0]  r_dst;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_tmp_a;
    logic [DATA_W-1:0] r_tmp_b;
    logic [IDX_W-1:0]  r_cnt;

    logic              w_save;
    logic [IDX_W-1:0]  w_save_sel;
    logic [DATA_W-1:0] w_save_data;
    logic [IDX_W-1:0]  w_load_sel;
    logic              w_done;
    logic              w_error;
    logic              w_cmd_bad;
    logic              w_accept;

    // Operand legality of the command currently offered on cmd_*
    always_comb begin
        w_cmd_bad = 1'b0;
        if (((cmd_op == OP_LDI) || (cmd_op == OP_MOV)) && (cmd_dst > LAST_IDX))
            w_cmd_bad = 1'b1;
        if (((cmd_op == OP_MOV) || (cmd_op == OP_SWAP)) && (cmd_src > LAST_IDX))
            w_cmd_bad = 1'b1;
    end

    assign w_accept = cmd_valid && (r_state == S_IDLE);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Operand latch, read captures and clear counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_op    <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_imm   <= '0;
            r_tmp_a <= '0;
            r_tmp_b <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= cmd_op;
                r_src <= cmd_src;
                r_dst <= cmd_dst;
                r_imm <= cmd_imm;
                r_cnt <= '0;
            end
            if (r_state == S_READ_A) r_tmp_a <= rf_loadbus;
            if (r_state == S_READ_B) r_tmp_b <= rf_loadbus;
            if (r_state == S_CLEAR)  r_cnt   <= (r_cnt == LAST_IDX) ? '0 : r_cnt + IDX_W'(1);
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next      = r_state;
        w_save      = 1'b0;
        w_save_sel  = '0;
        w_save_data = '0;
        w_load_sel  = '0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (w_cmd_bad) begin
                        w_next = S_ERR;
                    end else begin
                        case (cmd_op)
                            OP_LDI:  w_next = S_WRITE_A;
                            OP_CLR:  w_next = S_CLEAR;
                            default: w_next = S_READ_A;
                        endcase
                    end
                end
            end
            S_READ_A: begin
                w_load_sel = r_src;
                w_next     = (r_op == OP_SWAP) ? S_READ_B : S_WRITE_A;
            end
            S_READ_B: begin
                w_load_sel = r_dst;
                w_next     = S_WRITE_A;
            end
            S_WRITE_A: begin
                w_save      = 1'b1;
                w_save_sel  = r_dst;
                w_save_data = (r_op == OP_LDI) ? r_imm : r_tmp_a;
                if (r_op == OP_SWAP) begin
                    w_next = S_WRITE_B;
                end else begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_WRITE_B: begin
                w_save      = 1'b1;
                w_save_sel  = r_src;
                w_save_data = r_tmp_b;
                w_done      = 1'b1;
                w_next      = S_IDLE;
            end
            S_CLEAR: begin
                w_save     = 1'b1;
                w_save_sel = r_cnt;
                if (r_cnt == LAST_IDX) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_ERR: begin
                w_error = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Everything is forced quiet while reset is held low
    assign cmd_ready       = reset && (r_state == S_IDLE);
    assign rf_save         = reset && w_save;
    assign done            = reset && w_done;
    assign error           = reset && w_error;
    assign rf_saveselector = reset ? w_save_sel  : '0;
    assign rf_savebus      = reset ? w_save_data : '0;
    assign rf_loadselector = reset ? w_load_sel  : '0;

    // OP_MOV/OP_CLR are named for readability of the decode above
    logic w_unused;
    assign w_unused = (OP_MOV == OP_CLR);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with an attached register-file model.
module tb_regfile_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_src = 3'd0;
    logic [2:0] cmd_dst = 3'd0;
    logic [7:0] cmd_imm = 8'd0;
    logic       rf_save;
    logic [2:0] rf_saveselector;
    logic [7:0] rf_savebus;
    logic [2:0] rf_loadselector;
    logic [7:0] rf_loadbus;
    logic       done;
    logic       error;

    regfile_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rf_save(rf_save), .rf_saveselector(rf_saveselector), .rf_savebus(rf_savebus),
        .rf_loadselector(rf_loadselector), .rf_loadbus(rf_loadbus),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Register file attached to the sequencer (environment, not the reference)
    logic [7:0] rf [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    always_comb begin
        rf_loadbus = 8'h00;
        for (int i = 0; i < 6; i++)
            if (int'(rf_loadselector) == i) rf_loadbus = rf[i];
    end
    always @(posedge clock)
        if (rf_save)
            for (int i = 0; i < 6; i++)
                if (int'(rf_saveselector) == i) rf[i] <= rf_savebus;

    // Reference register contents, updated per command at the architectural level
    logic [7:0] mdl [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

    typedef struct {
        bit         err;
        bit         dn;
        logic [2:0] idx;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] LDI = 2'd0, MOV = 2'd1, SWP = 2'd2, CLR = 2'd3;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input bit err, input bit dn, input logic [2:0] idx,
                        input logic [7:0] data, input int c);
        exp_t e;
        e.err = err; e.dn = dn; e.idx = idx; e.data = data; e.cyc = c;
        sbq.push_back(e);
    endtask

    // Monitor: every write/done/error presented by the DUT must match the next expectation
    exp_t me;
    always @(negedge clock) begin
        if (rf_save || done || error) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: save=%b idx=%0d data=%h done=%b err=%b cyc=%0d",
                         rf_save, rf_saveselector, rf_savebus, done, error, cyc);
            end else begin
                me = sbq.pop_front();
                if (me.err ? (!error || rf_save || done || cyc != me.cyc)
                           : (!rf_save || error || rf_saveselector != me.idx ||
                              rf_savebus != me.data || done != me.dn || cyc != me.cyc)) begin
                    n_bad++;
                    $display("FAIL sb_event: got save=%b idx=%0d data=%h done=%b err=%b cyc=%0d; expected err=%b idx=%0d data=%h done=%b cyc=%0d",
                             rf_save, rf_saveselector, rf_savebus, done, error, cyc,
                             me.err, me.idx, me.data, me.dn, me.cyc);
                end
            end
        end
    end

    // Issue one command; abort_k>0 pulls reset low during busy cycle abort_k
    task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [7:0] imm, input int abort_k, input int gap);
        int e_cyc, lat, k, t;
        bit bad;
        logic [7:0] a, b;
        t = 0;
        while (!cmd_ready && t < 50) begin
            cmd_valid = 1'b0;
            @(posedge clock); #1; t++;
        end
        if (t >= 50) chk("ready_timeout_pre", 0, 1);
        for (int g = 0; g < gap; g++) begin
            cmd_valid = 1'b0;
            @(posedge clock); #1;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        e_cyc = cyc + 1;
        bad = (((op == LDI) || (op == MOV)) && dst > 5) || (((op == MOV) || (op == SWP)) && src > 5);
        if (bad) begin
            push(1'b1, 1'b0, 3'd0, 8'd0, e_cyc);
            lat = 1;
        end else begin
            case (op)
                LDI: begin push(1'b0, 1'b1, dst, imm, e_cyc); mdl[dst] = imm; lat = 1; end
                MOV: begin a = mdl[src]; push(1'b0, 1'b1, dst, a, e_cyc + 1); mdl[dst] = a; lat = 2; end
                SWP: begin
                    a = mdl[src]; b = mdl[dst];
                    push(1'b0, 1'b0, dst, a, e_cyc + 2);
                    mdl[dst] = a;
                    if (abort_k != 4) begin
                        push(1'b0, 1'b1, src, b, e_cyc + 3);
                        mdl[src] = b;
                    end
                    lat = 4;
                end
                default: begin
                    for (int i = 0; i < 6; i++) begin
                        push(1'b0, i == 5, 3'(i), 8'd0, e_cyc + i);
                        mdl[i] = 8'd0;
                    end
                    lat = 6;
                end
            endcase
        end
        @(posedge clock); #1;
        k = 1;
        while (!cmd_ready && k < 40) begin
            if (!bad && (op == MOV || op == SWP) && k == 1) chk("loadsel_src", int'(rf_loadselector), int'(src));
            if (!bad && op == SWP && k == 2) chk("loadsel_dst", int'(rf_loadselector), int'(dst));
            if (k == abort_k) begin
                reset = 1'b0;
                cmd_valid = 1'($urandom);
                @(posedge clock); #1;
                chk("ready_in_reset", int'(cmd_ready), 0);
                chk("save_in_reset", int'(rf_save), 0);
                reset = 1'b1; cmd_valid = 1'b0;
                #1;
                chk("ready_after_reset", int'(cmd_ready), 1);
                return;
            end
            // Operands presented while busy must be ignored
            cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
            cmd_src = 3'($urandom); cmd_dst = 3'($urandom); cmd_imm = 8'($urandom);
            @(posedge clock); #1;
            k++;
        end
        cmd_valid = 1'b0;
        chk("busy_cycles", k - 1, lat);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (rf[i] !== mdl[i]) begin
                n_bad++;
                $display("FAIL rf_%s[%0d]: got %h expected %h", tag, i, rf[i], mdl[i]);
            end
        end
    endtask

    function automatic logic [2:0] rnd_idx();
        return ($urandom_range(0, 15) < 13) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
    endfunction

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [1:0] op;
        logic [2:0] s, d;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_save", int'(rf_save), 0);
        chk("rst_done_err", int'({done, error}), 0);
        chk("rst_sel_bus", int'({rf_saveselector, rf_savebus, rf_loadselector}), 0);
        reset = 1'b1;
        #1;
        chk("ready_after_rst", int'(cmd_ready), 1);

        issue(LDI, 3'd0, 3'd2, 8'h5A, 0, 0);
        issue(LDI, 3'd0, 3'd1, 8'h11, 0, 0);
        issue(LDI, 3'd0, 3'd4, 8'h44, 0, 1);
        issue(MOV, 3'd4, 3'd1, 8'h00, 0, 0);
        check_rf("mov");
        issue(LDI, 3'd0, 3'd1, 8'h11, 0, 0);
        issue(SWP, 3'd1, 3'd4, 8'h00, 0, 0);
        check_rf("swap");
        issue(CLR, 3'd7, 3'd7, 8'hFF, 0, 0);
        check_rf("clr");
        issue(LDI, 3'd0, 3'd0, 8'h77, 0, 0);
        issue(MOV, 3'd6, 3'd0, 8'h00, 0, 0);
        issue(LDI, 3'd0, 3'd7, 8'h99, 0, 0);
        check_rf("err");
        issue(MOV, 3'd3, 3'd3, 8'h00, 0, 0);
        issue(SWP, 3'd5, 3'd5, 8'h00, 0, 0);
        issue(LDI, 3'd0, 3'd1, 8'h11, 0, 0);
        issue(LDI, 3'd0, 3'd4, 8'h44, 0, 0);
        issue(SWP, 3'd1, 3'd4, 8'h00, 4, 0);
        chk("abort_dst", int'(rf[4]), 8'h11);
        chk("abort_src", int'(rf[1]), 8'h11);
        check_rf("abort");

        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            s = rnd_idx();
            d = (op == SWP) ? 3'($urandom_range(0, 5)) : rnd_idx();
            if (op == CLR && $urandom_range(0, 3) != 0) op = LDI;
            issue(op, s, d, 8'($urandom), 0, $urandom_range(0, 2));
            if (n % 50 == 49) check_rf("rand");
        end

        repeat (3) @(posedge clock);
        #1;
        chk("sb_drained", sbq.size(), 0);
        check_rf("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven sequencer in front of the 6-entry, 8-bit register file (indices 0–5). It owns the file's single save port and its load selector, and turns one-word commands into multi-cycle read/write sequences. Supported commands are load-immediate, move, swap and clear-all. It sits between the instruction decoder, which issues commands over a valid/ready handshake, and the register file; the file's fixed ALU taps (indices 1, 2, 3) are not touched.

## Interface
Parameters:
- none; data width is 8 and register count is 6, both fixed.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command; a command transfers on a rising edge with cmd_valid && cmd_ready
- cmd_op  in  2  00 LDI, 01 MOV, 10 SWAP, 11 CLR
- cmd_src  in  3  source index (MOV, SWAP)
- cmd_dst  in  3  destination index (LDI, MOV, SWAP)
- cmd_imm  in  8  immediate value (LDI)
- rf_save  out  1  register-file write enable
- rf_saveselector  out  3  write index
- rf_savebus  out  8  write data
- rf_loadselector  out  3  read index
- rf_loadbus  in  8  read data; combinational from rf_loadselector within the same cycle
- done  out  1  one-cycle pulse, coincident with the final write of a command
- error  out  1  one-cycle pulse for a rejected command

## Operation
- FSM states: IDLE, READ_A, READ_B, WRITE_A, WRITE_B, CLEAR, ERR.
- Registered operands latched on accept: op, src, dst, imm. Internal 8-bit registers: tmpA, tmpB. 3-bit clear counter.
- cmd_ready is 1 only in IDLE, and only while reset is high.
- Command validation on accept:
  - LDI and MOV: dst > 5 is invalid.
  - MOV and SWAP: src > 5 is invalid.
  - CLR ignores src, dst and imm.
  - Invalid command → ERR for one cycle (error=1, no write) → IDLE.
- LDI: IDLE → WRITE_A (save dst ← imm, done=1) → IDLE.
- MOV: IDLE → READ_A (loadselector=src; tmpA ← rf_loadbus at the edge) → WRITE_A (save dst ← tmpA, done=1) → IDLE.
- SWAP: IDLE → READ_A (capture src into tmpA) → READ_B (loadselector=dst; capture into tmpB) → WRITE_A (dst ← tmpA) → WRITE_B (src ← tmpB, done=1) → IDLE.
- CLR: IDLE → CLEAR for 6 cycles. Each cycle writes index = counter, data 0; counter runs 0..5. done=1 on index 5, then IDLE.
- src == dst is legal. MOV rewrites the same value; SWAP leaves the register unchanged. Both still raise done.
- Output defaults outside the states above: rf_save=0, rf_saveselector=0, rf_savebus=0, rf_loadselector=0.
- rf_save is gated with reset, so no write commits in any cycle while reset is low.

## Timing
- All outputs other than rf_save/cmd_ready gating are pure decodes of registered state (Moore); no output depends combinationally on cmd_*.
- Accept at edge N. Busy cycles after accept: LDI 1, MOV 2, SWAP 4, CLR 6, ERR 1.
- cmd_ready returns high in the cycle after the done/error cycle. Back-to-back throughput is therefore latency+1 cycles per command.
- Each write commits at the rising edge that ends its WRITE/CLEAR cycle. A read captures rf_loadbus at the edge that ends its READ cycle.
- Reset (reset=0 at an edge): state→IDLE, tmpA/tmpB/counter/operand registers→0. Outputs rf_save=0, selectors=0, savebus=0, done=0, error=0, cmd_ready=0 while reset is low, then 1.
- Reset mid-command: the sequence is abandoned. Writes already committed remain (for example, SWAP reset during WRITE_B leaves dst updated and src unchanged). No done pulse.
- cmd_valid may rise or fall at any time. It is sampled only in IDLE; operands are ignored in every other state.

## Test plan
- Reset, then LDI dst=2 imm=0x5A: rf_save=1, saveselector=2, savebus=0x5A exactly one cycle after accept, with done in that cycle; cmd_ready low 1 cycle, high the next.
- Preload r1=0x11, r4=0x44; MOV src=4 dst=1: loadselector=4 in cycle N+1, then a write of r1←0x44 in N+2 with done; r1 reads 0x44 and r4 stays 0x44.
- SWAP src=1 dst=4 (r1=0x11, r4=0x44): four busy cycles; writes are r4←0x11 in N+3 and r1←0x44 in N+4; done only in N+4.
- CLR with all registers nonzero: six consecutive writes of 0 to indices 0..5, done on index 5; all registers then read 0x00.
- MOV src=6 dst=0, then LDI dst=7: each produces error for one cycle, rf_save never asserts, and r0 is unchanged.
- SWAP in progress, reset low during WRITE_B: rf_save=0 in that cycle, no done, dst holds the swapped value, src keeps its original, and cmd_ready=1 after reset releases.
